// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg : shared active-low seven-segment constants ({g,f,e,d,c,b,a}).
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [3:0] AN_D0  = 4'hE;
  localparam logic [3:0] AN_D1  = 4'hD;

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7 : combinational nibble to active-low seven-segment decoder.
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hex2_scan_display.sv
// ---------------------------------------------------------------------------
// hex2_scan_display : captures a byte on a load edge and scans it as two hex
//                     digits onto a 4-digit common-anode display.
// Rev 1.0           : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hex2_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       tick,
  output logic [7:0] cur_byte
);

  logic [CNT_W-1:0] cnt;
  logic             digit;
  logic             load_q;
  logic [7:0]       disp_reg;

  logic             wrap;
  logic             load_edge;
  logic [3:0]       nibble;
  logic [6:0]       nibble_seg;
  logic             blank_hi;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;

  assign wrap      = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign load_edge = load & ~load_q;
  assign nibble    = digit ? disp_reg[7:4] : disp_reg[3:0];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (nibble_seg)
  );

  generate
    if (BLANK_LZ != 0) begin : g_blank_lz
      assign blank_hi = digit && (disp_reg[7:4] == 4'h0);
    end else begin : g_no_blank_lz
      assign blank_hi = 1'b0;
    end
  endgenerate

  // an[3:2] stay off because both digit anode constants carry 2'b11 there.
  always_comb begin
    an_nxt  = digit ? AN_D1 : AN_D0;
    seg_nxt = nibble_seg;
    if (blank_hi) begin
      an_nxt  = AN_OFF;
      seg_nxt = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      digit    <= 1'b0;
      load_q   <= 1'b0;
      disp_reg <= 8'h00;
      tick     <= 1'b0;
      an       <= AN_OFF;
      seg      <= SEG_BLANK;
    end else begin
      load_q <= load;
      if (load_edge) begin
        disp_reg <= din;
      end
      if (wrap) begin
        cnt   <= '0;
        digit <= ~digit;
        tick  <= 1'b1;
      end else begin
        cnt   <= cnt + CNT_W'(1);
        tick  <= 1'b0;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

  assign dp       = 1'b1;
  assign cur_byte = disp_reg;

endmodule

`default_nettype wire

// File: tb/tb_hex2_scan_display.sv
// ---------------------------------------------------------------------------
// tb_hex2_scan_display : directed bench for hex2_scan_display, two instances
//                        differing only in leading-zero blanking.
// Rev 1.0              : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hex2_scan_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       load;

  logic [3:0] an,    an_nb;
  logic [6:0] seg,   seg_nb;
  logic       dp,    dp_nb;
  logic       tick,  tick_nb;
  logic [7:0] cur,   cur_nb;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  always #5 clk = ~clk;

  hex2_scan_display #(.REFRESH_DIV(4), .CNT_W(2), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load),
    .an(an), .seg(seg), .dp(dp), .tick(tick), .cur_byte(cur)
  );

  hex2_scan_display #(.REFRESH_DIV(4), .CNT_W(2), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb), .tick(tick_nb), .cur_byte(cur_nb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    din   = 8'h00;
    repeat (2) step();
    rst_n = 1'b1;
    k = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    din   = 8'h5A;

    // 1: reset state, then first edge after release
    repeat (3) step();
    chk("rst_an",   32'(an),   32'hF);
    chk("rst_seg",  32'(seg),  32'h7F);
    chk("rst_dp",   32'(dp),   32'h1);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_cur",  32'(cur),  32'h00);
    rst_n = 1'b1;
    k = 0;
    step();
    chk("rel_an",  32'(an),  32'hE);
    chk("rel_seg", 32'(seg), 32'h40);

    // 2: single-cycle load of A5
    din = 8'hA5; load = 1'b1;
    step();
    chk("a5_cur", 32'(cur), 32'hA5);
    load = 1'b0;
    step();
    chk("a5_an0",  32'(an),  32'hE);
    chk("a5_seg0", 32'(seg), 32'h12);
    step();
    chk("a5_tick", 32'(tick), 32'h1);
    step();
    chk("a5_an1",   32'(an),   32'hD);
    chk("a5_seg1",  32'(seg),  32'h08);
    chk("a5_tick0", 32'(tick), 32'h0);

    // 3: held load captures once; re-arm after one low cycle
    do_reset();
    din = 8'h3C; load = 1'b1;
    step();
    chk("hold_cap", 32'(cur), 32'h3C);
    repeat (9) step();
    din = 8'h7E;
    repeat (10) step();
    chk("hold_keep", 32'(cur), 32'h3C);
    load = 1'b0;
    step();
    chk("hold_low", 32'(cur), 32'h3C);
    load = 1'b1;
    step();
    chk("hold_recap", 32'(cur), 32'h7E);
    load = 1'b0;

    // 4: leading-zero blanking on and off
    do_reset();
    din = 8'h07; load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("lz_d0_an",     32'(an),     32'hE);
    chk("lz_d0_seg",    32'(seg),    32'h78);
    chk("nb_d0_seg",    32'(seg_nb), 32'h78);
    repeat (3) step();
    chk("lz_d1_an",     32'(an),     32'hF);
    chk("lz_d1_seg",    32'(seg),    32'h7F);
    chk("nb_d1_an",     32'(an_nb),  32'hD);
    chk("nb_d1_seg",    32'(seg_nb), 32'h40);
    repeat (4) step();
    chk("lz_d0b_an",    32'(an),     32'hE);
    chk("lz_d0b_seg",   32'(seg),    32'h78);

    // 5: free-run tick period and anode alternation
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      chk("fr_tick", 32'(tick), 32'((k % 4) == 0));
      chk("fr_an", 32'(an_nb), (((k - 1) / 4) % 2) ? 32'hD : 32'hE);
      chk("fr_an_hi", 32'(an[3:2]), 32'h3);
    end

    // 6: reset coincident with a load edge aborts the capture
    do_reset();
    din = 8'hFF; load = 1'b1;
    step();
    chk("ff_cur", 32'(cur), 32'hFF);
    load = 1'b0;
    step();
    din = 8'h42; load = 1'b1; rst_n = 1'b0;
    step();
    chk("abort_an",   32'(an),   32'hF);
    chk("abort_seg",  32'(seg),  32'h7F);
    chk("abort_tick", 32'(tick), 32'h0);
    chk("abort_cur",  32'(cur),  32'h00);
    load = 1'b0; rst_n = 1'b1;
    k = 0;
    step();
    chk("post_cur", 32'(cur), 32'h00);
    chk("post_an",  32'(an),  32'hE);
    chk("post_seg", 32'(seg), 32'h40);
    chk("post_dp",  32'(dp),  32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
